// File: rtl/gzip_block_unpacker_pkg.sv
// Shared types and helpers for the gzip block unpacker.
// Header layout, FSM encoding and the lane-index width.
package gzip_block_unpacker_pkg;

  localparam int WORD_W = 32;
  localparam int LEN_W = 24;
  localparam int HDR_BFINAL_BIT = 24;
  localparam int LANES = 4;

  function automatic int clogb2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int LANE_W = clogb2(LANES);

  typedef enum logic [2:0] {
    S_HDR_RD,
    S_HDR_WT,
    S_DAT_RD,
    S_DAT_WT,
    S_EMIT,
    S_BLK_END,
    S_DONE
  } state_t;

  typedef struct packed {
    logic             bfinal;
    logic [LEN_W-1:0] len;
  } hdr_t;

  // The header is big-endian inside a little-endian FIFO word:
  // byte 0 carries BFINAL in bit 0, bytes 1..3 carry LENGTH MSB first.
  function automatic hdr_t decode_hdr(input logic [WORD_W-1:0] w);
    hdr_t r;
    r.bfinal = w[HDR_BFINAL_BIT-24];
    r.len    = {w[15:8], w[23:16], w[31:24]};
    return r;
  endfunction

endpackage

// File: rtl/gzip_block_unpacker.sv
// Pops block headers and payload words from the input FIFO and
// serialises the payload into a byte stream, dropping pad bytes.
module gzip_block_unpacker
  import gzip_block_unpacker_pkg::*;
#(
  parameter int LEN_WIDTH  = 24,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [WORD_W-1:0]     fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] byte_out,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  block_start,
  output logic                  block_done,
  output logic                  bfinal,
  output logic [LEN_WIDTH-1:0]  block_len,
  output logic                  stream_done
);

  state_t              state;
  logic [WORD_W-1:0]   hold;
  logic [LANE_W-1:0]   lane;
  logic [LANE_W-1:0]   next_lane;
  logic [LEN_WIDTH-1:0] bytes_left;
  logic [7:0]          next_byte;
  logic                rd_state;
  hdr_t                hdr;

  assign hdr = decode_hdr(fifo_dout);

  assign rd_state = (state == S_HDR_RD) || (state == S_DAT_RD);

  // Pop only when data exists; reset must hold every output low.
  assign fifo_rd_en = rd_state && !fifo_empty && !rst;

  assign next_lane = lane + LANE_W'(1);

  always_comb begin
    next_byte = 8'h00;
    unique case (next_lane)
      2'd0: next_byte = hold[7:0];
      2'd1: next_byte = hold[15:8];
      2'd2: next_byte = hold[23:16];
      2'd3: next_byte = hold[31:24];
      default: next_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_HDR_RD;
      hold        <= '0;
      lane        <= '0;
      bytes_left  <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      block_start <= 1'b0;
      block_done  <= 1'b0;
      bfinal      <= 1'b0;
      block_len   <= '0;
      stream_done <= 1'b0;
    end else begin
      block_start <= 1'b0;
      block_done  <= 1'b0;
      unique case (state)
        S_HDR_RD: begin
          if (!fifo_empty) state <= S_HDR_WT;
        end
        S_HDR_WT: begin
          bfinal      <= hdr.bfinal;
          block_len   <= LEN_WIDTH'(hdr.len);
          bytes_left  <= LEN_WIDTH'(hdr.len);
          block_start <= 1'b1;
          if (hdr.len == '0) state <= S_BLK_END;
          else state <= S_DAT_RD;
        end
        S_DAT_RD: begin
          if (!fifo_empty) state <= S_DAT_WT;
        end
        S_DAT_WT: begin
          hold       <= fifo_dout;
          lane       <= '0;
          byte_out   <= DATA_WIDTH'(fifo_dout[7:0]);
          byte_valid <= 1'b1;
          state      <= S_EMIT;
        end
        S_EMIT: begin
          if (byte_valid && byte_ready) begin
            if (bytes_left != '0) bytes_left <= bytes_left - LEN_WIDTH'(1);
            lane <= next_lane;
            // Pad lanes after the block's last byte are never shown.
            if (bytes_left == LEN_WIDTH'(1)) begin
              byte_valid <= 1'b0;
              state      <= S_BLK_END;
            end else if (lane == LANE_W'(LANES - 1)) begin
              byte_valid <= 1'b0;
              state      <= S_DAT_RD;
            end else begin
              byte_out <= DATA_WIDTH'(next_byte);
            end
          end
        end
        S_BLK_END: begin
          block_done <= 1'b1;
          if (bfinal) begin
            stream_done <= 1'b1;
            state       <= S_DONE;
          end else begin
            state <= S_HDR_RD;
          end
        end
        S_DONE: begin
          stream_done <= 1'b1;
        end
        default: state <= S_HDR_RD;
      endcase
    end
  end

endmodule

// File: tb/tb_gzip_block_unpacker.sv
// Scoreboard bench for gzip_block_unpacker: a queue-based FIFO and
// block model produce expected bytes and headers; a monitor checks.
module tb_gzip_block_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        block_start;
  logic        block_done;
  logic        bfinal;
  logic [23:0] block_len;
  logic        stream_done;

  int errors = 0;
  int checks = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  int acc_cnt = 0;
  int rmode = 0;
  int gap_cnt = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] pend_q[$];
  int          gap_q[$];
  logic [7:0]  stage_q[$];
  logic [7:0]  exp_b[$];
  logic [24:0] exp_h[$];

  gzip_block_unpacker #(.LEN_WIDTH(24), .DATA_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .byte_out(byte_out),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .block_start(block_start),
    .block_done(block_done),
    .bfinal(bfinal),
    .block_len(block_len),
    .stream_done(stream_done)
  );

  always #5 clk = ~clk;

  // FIFO model: words become visible after their gap, data one cycle after pop.
  always @(negedge clk) begin
    if (gap_cnt > 0) begin
      gap_cnt = gap_cnt - 1;
    end else if (pend_q.size() > 0) begin
      fifo_q.push_back(pend_q.pop_front());
      gap_cnt = gap_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_dout  <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      rcnt++;
      case (rmode)
        0: byte_ready = 1'b1;
        1: byte_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
        default: byte_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor / scoreboard
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;
  logic       sd_seen = 1'b0;
  int         blk_bytes = 0;
  int         cur_len = 0;

  always @(negedge clk) begin
    logic [7:0]  eb;
    logic [24:0] eh;
    if (tmo_cnt != tmo_seen) begin
      tmo_seen = tmo_cnt;
      checks++;
      errors++;
      $display("FAIL stream_timeout: stream_done=%0b required 1", stream_done);
    end
    if (rst) begin
      checks++;
      if (byte_valid || byte_out != 0 || fifo_rd_en || block_start ||
          block_done || bfinal || block_len != 0 || stream_done) begin
        errors++;
        $display("FAIL reset_outputs: v=%0b b=%h rd=%0b bs=%0b bd=%0b bf=%0b len=%0d sd=%0b required all 0",
                 byte_valid, byte_out, fifo_rd_en, block_start, block_done,
                 bfinal, block_len, stream_done);
      end
      prev_stall = 1'b0;
      sd_seen = 1'b0;
      blk_bytes = 0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!byte_valid || byte_out != prev_byte) begin
          errors++;
          $display("FAIL stall_stable: v=%0b byte=%h required v=1 byte=%h",
                   byte_valid, byte_out, prev_byte);
        end
      end
      if (byte_valid && byte_ready) begin
        checks++;
        acc_cnt++;
        blk_bytes++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL byte_extra: got %h required no byte", byte_out);
        end else begin
          eb = exp_b.pop_front();
          if (byte_out != eb) begin
            errors++;
            $display("FAIL byte: got %h required %h", byte_out, eb);
          end
        end
      end
      prev_stall = byte_valid && !byte_ready;
      prev_byte = byte_out;
      if (block_start) begin
        checks++;
        blk_bytes = 0;
        if (exp_h.size() == 0) begin
          errors++;
          $display("FAIL hdr_extra: got bf=%0b len=%0d required none", bfinal, block_len);
        end else begin
          eh = exp_h.pop_front();
          cur_len = int'(eh[23:0]);
          if ({bfinal, block_len} != eh) begin
            errors++;
            $display("FAIL hdr: got bf=%0b len=%0d required bf=%0b len=%0d",
                     bfinal, block_len, eh[24], eh[23:0]);
          end
        end
      end
      if (block_done) begin
        checks++;
        if (blk_bytes != cur_len) begin
          errors++;
          $display("FAIL block_done_count: got %0d bytes required %0d", blk_bytes, cur_len);
        end
      end
      if (stream_done && !sd_seen) begin
        sd_seen = 1'b1;
        checks++;
        if (exp_b.size() != 0 || exp_h.size() != 0 || !bfinal) begin
          errors++;
          $display("FAIL stream_done_early: pending bytes=%0d hdrs=%0d bf=%0b required 0 0 1",
                   exp_b.size(), exp_h.size(), bfinal);
        end
      end
      if (fifo_rd_en) begin
        checks++;
        if (fifo_empty || stream_done) begin
          errors++;
          $display("FAIL rd_en: rd_en=1 empty=%0b done=%0b required rd_en=0",
                   fifo_empty, stream_done);
        end
      end
    end
  end

  task automatic push_word(input logic [31:0] w, input int gap);
    pend_q.push_back(w);
    gap_q.push_back(gap);
  endtask

  task automatic stage(input string s);
    for (int i = 0; i < s.len(); i++) stage_q.push_back(s[i]);
  endtask

  // Reference block: header word, then ceil(len/4) little-endian words.
  task automatic add_block(input bit bf, input int len, input int gap);
    logic [31:0] w;
    logic [7:0]  b;
    int          nw;
    nw = (len + 3) / 4;
    w = {len[7:0], len[15:8], len[23:16], 7'($urandom), bf};
    push_word(w, gap);
    exp_h.push_back({bf, len[23:0]});
    for (int i = 0; i < nw; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (stage_q.size() > 0) b = stage_q.pop_front();
        else b = 8'($urandom);
        w[8*k +: 8] = b;
        if (4 * i + k < len) exp_b.push_back(b);
      end
      push_word(w, gap);
    end
    stage_q.delete();
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #2;
    rst = 1'b1;
    pend_q.delete();
    gap_q.delete();
    fifo_q.delete();
    exp_b.delete();
    exp_h.delete();
    stage_q.delete();
    repeat (cycles) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // A trailing junk word must never be read once the stream is done.
  task automatic finish_stream();
    bit ok;
    push_word(32'hdead_beef, 0);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #2;
      if (stream_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) tmo_cnt++;
    repeat (8) @(posedge clk);
  endtask

  initial begin
    do_reset(3);
    rmode = 0;
    stage("abcdeaba");
    add_block(1, 7, 0);
    finish_stream();

    do_reset(2);
    stage("abcdef..");
    add_block(0, 6, 0);
    stage("ghabx...");
    add_block(1, 5, 0);
    finish_stream();

    do_reset(2);
    rmode = 1;
    stage("abcdeaba");
    add_block(1, 7, 0);
    finish_stream();

    do_reset(2);
    rmode = 0;
    add_block(0, 0, 0);
    stage("z...");
    add_block(1, 1, 0);
    finish_stream();

    do_reset(2);
    stage("abcdeaba");
    add_block(1, 7, 10);
    finish_stream();

    do_reset(2);
    acc_cnt = 0;
    stage("abcdeaba");
    add_block(1, 7, 0);
    for (int c = 0; c < 200 && acc_cnt < 2; c++) @(posedge clk);
    do_reset(3);
    stage("abcdeaba");
    add_block(1, 7, 0);
    finish_stream();

    rmode = 2;
    for (int s = 0; s < 8; s++) begin
      int nb;
      do_reset(2);
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++)
        add_block(b == nb - 1, $urandom_range(0, 13), $urandom_range(0, 3));
      finish_stream();
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
